// File: rtl/io_log_sink.sv
// CPU output-port log sink: queues 64-bit words written by the CPU and
// serialises them MSB-first as a byte stream with valid/ready handshaking.
module io_log_sink #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     io_write,
  input  logic [63:0]              io_data,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_last,
  input  logic                     tx_ready,
  input  logic                     clr_stats,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [31:0]              word_count,
  output logic                     idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [63:0]     shift_q, shift_d;
  logic [2:0]      idx_q, idx_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_q, drop_d;
  logic [31:0]     wc_q, wc_d;

  logic fifo_empty;
  logic fifo_full;
  logic handshake;
  logic last_hs;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    handshake  = (state_q == SEND) && tx_ready;
    last_hs    = handshake && (idx_q == 3'd7);
    // A pop frees a slot this cycle, so a write into a full FIFO still lands.
    pop        = !fifo_empty && ((state_q == IDLE) || last_hs);
    push       = io_write && (!fifo_full || pop);
    drop       = io_write && !push;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (idx_q != 3'd7) begin
            shift_d = {shift_q[55:0], 8'h00};
            idx_d   = idx_q + 3'd1;
          end else if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear first, then fold in this cycle's drop or word completion.
  always_comb begin
    overflow_d = clr_stats ? 1'b0  : overflow_q;
    drop_d     = clr_stats ? 16'd0 : drop_q;
    wc_d       = clr_stats ? 32'd0 : wc_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_d != '1) begin
        drop_d = drop_d + 16'd1;
      end
    end
    if (last_hs) begin
      wc_d = wc_d + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      wc_q       <= wc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= io_data;
    end
  end

  always_comb begin
    tx_valid   = (state_q == SEND);
    tx_data    = shift_q[63:56];
    tx_last    = (state_q == SEND) && (idx_q == 3'd7);
    fifo_count = count_q;
    overflow   = overflow_q;
    drop_count = drop_q;
    word_count = wc_q;
    idle       = (state_q == IDLE) && fifo_empty;
  end

endmodule
